// File: rtl/breath_ramp_gen_if.sv
// Control and duty-ramp signals between the breathing-ramp generator and the
// downstream PWM comparator stage.
interface breath_ramp_gen_if;
  logic        en;
  logic        mode;
  logic [31:0] period_cnt;
  logic [31:0] duty;
  logic        period_start;
  logic        rising;
  logic        at_peak;

  modport master (
    input  en,
    input  mode,
    output period_cnt,
    output duty,
    output period_start,
    output rising,
    output at_peak
  );

  modport slave (
    output en,
    output mode,
    input  period_cnt,
    input  duty,
    input  period_start,
    input  rising,
    input  at_peak
  );
endinterface

// File: rtl/breath_ramp_gen.sv
// PWM period counter plus a triangle/sawtooth duty ramp. Duty updates land
// only on the period wrap, so the downstream comparator never sees a glitch.
module breath_ramp_gen #(
  parameter int unsigned LENGTH      = 30,
  parameter int unsigned SPEED_DOWN  = 300,
  parameter int unsigned HOLD_TOP    = 0,
  parameter int unsigned HOLD_BOTTOM = 0
) (
  input  logic              clk,
  input  logic              rst,
  breath_ramp_gen_if.master bus
);

  localparam logic [31:0] LEN_C = 32'(LENGTH);
  localparam logic [31:0] SPD_C = 32'(SPEED_DOWN);
  localparam logic [31:0] TOP_C = 32'(HOLD_TOP);
  localparam logic [31:0] BOT_C = 32'(HOLD_BOTTOM);

  typedef enum logic [1:0] {
    ST_RISE    = 2'd0,
    ST_HOLD_HI = 2'd1,
    ST_FALL    = 2'd2,
    ST_HOLD_LO = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] period_cnt_q;
  logic [31:0] step_cnt_q;
  logic [31:0] duty_q, duty_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic        pending_q;
  logic        period_start_q;

  logic        wrap;
  logic        step;
  logic        apply;
  logic [31:0] hold_inc;

  assign wrap     = (period_cnt_q == LEN_C - 32'd1);
  assign step     = (step_cnt_q == SPD_C - 32'd1);
  // A step tick seen mid-period waits in pending; a coincident one applies now.
  assign apply    = wrap && (pending_q || step);
  assign hold_inc = hold_cnt_q + 32'd1;

  // State register and counters.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_RISE;
      period_cnt_q   <= '0;
      step_cnt_q     <= '0;
      duty_q         <= '0;
      hold_cnt_q     <= '0;
      pending_q      <= 1'b0;
      period_start_q <= 1'b0;
    end else if (bus.en) begin
      period_cnt_q   <= wrap ? '0 : period_cnt_q + 32'd1;
      step_cnt_q     <= step ? '0 : step_cnt_q + 32'd1;
      period_start_q <= wrap;
      if (apply)     pending_q <= 1'b0;
      else if (step) pending_q <= 1'b1;
      state_q    <= state_d;
      duty_q     <= duty_d;
      hold_cnt_q <= hold_cnt_d;
    end else begin
      period_start_q <= 1'b0;
    end
  end

  // Next-state and duty update, evaluated only on an applied tick.
  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    hold_cnt_d = hold_cnt_q;
    if (apply) begin
      unique case (state_q)
        ST_RISE: begin
          if (duty_q == LEN_C) begin
            // Parked at the top in sawtooth with no hold; mode is re-read here.
            if (bus.mode) begin
              duty_d     = '0;
              hold_cnt_d = '0;
              state_d    = (BOT_C != 0) ? ST_HOLD_LO : ST_RISE;
            end else begin
              duty_d  = duty_q - 32'd1;
              state_d = ST_FALL;
            end
          end else begin
            duty_d = duty_q + 32'd1;
            if (duty_q + 32'd1 == LEN_C) begin
              if (TOP_C != 0) begin
                state_d    = ST_HOLD_HI;
                hold_cnt_d = '0;
              end else if (!bus.mode) begin
                state_d = ST_FALL;
              end
            end
          end
        end
        ST_HOLD_HI: begin
          hold_cnt_d = hold_inc;
          if (hold_inc >= TOP_C) begin
            if (!bus.mode) begin
              state_d = ST_FALL;
            end else begin
              duty_d     = '0;
              hold_cnt_d = '0;
              state_d    = (BOT_C != 0) ? ST_HOLD_LO : ST_RISE;
            end
          end
        end
        ST_FALL: begin
          if (duty_q <= 32'd1) begin
            duty_d     = '0;
            hold_cnt_d = '0;
            state_d    = (BOT_C != 0) ? ST_HOLD_LO : ST_RISE;
          end else begin
            duty_d = duty_q - 32'd1;
          end
        end
        ST_HOLD_LO: begin
          hold_cnt_d = hold_inc;
          if (hold_inc >= BOT_C) state_d = ST_RISE;
        end
        default: state_d = ST_RISE;
      endcase
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    bus.rising  = (state_q == ST_RISE) || (state_q == ST_HOLD_LO);
    bus.at_peak = (state_q == ST_HOLD_HI);
  end

  assign bus.period_cnt   = period_cnt_q;
  assign bus.duty         = duty_q;
  assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_breath_ramp_gen.sv
// Directed bench for breath_ramp_gen: triangle, sawtooth, enable freeze,
// tick absorption and asynchronous reset mid-ramp.
module tb_breath_ramp_gen;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_err;

  breath_ramp_gen_if bus_a ();
  breath_ramp_gen_if bus_b ();

  breath_ramp_gen #(
    .LENGTH(4), .SPEED_DOWN(8), .HOLD_TOP(1), .HOLD_BOTTOM(0)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  breath_ramp_gen #(
    .LENGTH(4), .SPEED_DOWN(1), .HOLD_TOP(1), .HOLD_BOTTOM(0)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Advance to 1 time unit after rising edge number 'target' since reset release.
  task automatic go_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset(input logic mode_a);
    @(negedge clk);
    rst = 1'b0;
    bus_a.en = 1'b1;
    bus_a.mode = mode_a;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    cyc = 0;
  endtask

  initial begin
    n_checks   = 0;
    n_err      = 0;
    cyc        = 0;
    rst        = 1'b0;
    bus_a.en   = 1'b1;
    bus_a.mode = 1'b0;
    bus_b.en   = 1'b1;
    bus_b.mode = 1'b0;

    // Reset values while rst is held low.
    repeat (3) @(negedge clk);
    check("rst_duty",   bus_a.duty, 32'd0);
    check("rst_pcnt",   bus_a.period_cnt, 32'd0);
    check("rst_rising", {31'd0, bus_a.rising}, 32'd1);
    check("rst_peak",   {31'd0, bus_a.at_peak}, 32'd0);
    check("rst_pstart", {31'd0, bus_a.period_start}, 32'd0);

    // Triangle ramp.
    do_reset(1'b0);
    go_to(1);  check("tri_pcnt1", bus_a.period_cnt, 32'd1);
    go_to(3);  check("tri_pcnt3", bus_a.period_cnt, 32'd3);
    check("tri_ps3", {31'd0, bus_a.period_start}, 32'd0);
    go_to(4);  check("tri_pcnt4", bus_a.period_cnt, 32'd0);
    check("tri_ps4", {31'd0, bus_a.period_start}, 32'd1);
    go_to(5);  check("tri_ps5", {31'd0, bus_a.period_start}, 32'd0);
    go_to(7);  check("tri_duty7", bus_a.duty, 32'd0);
    go_to(8);  check("tri_duty8", bus_a.duty, 32'd1);
    check("tri_ps8", {31'd0, bus_a.period_start}, 32'd1);
    go_to(12); check("tri_ps12", {31'd0, bus_a.period_start}, 32'd1);
    check("tri_duty12", bus_a.duty, 32'd1);
    go_to(16); check("tri_duty16", bus_a.duty, 32'd2);
    go_to(24); check("tri_duty24", bus_a.duty, 32'd3);
    go_to(31); check("tri_peak31", {31'd0, bus_a.at_peak}, 32'd0);
    go_to(32); check("tri_duty32", bus_a.duty, 32'd4);
    check("tri_peak32", {31'd0, bus_a.at_peak}, 32'd1);
    go_to(39); check("tri_peak39", {31'd0, bus_a.at_peak}, 32'd1);
    go_to(40); check("tri_peak40", {31'd0, bus_a.at_peak}, 32'd0);
    check("tri_duty40", bus_a.duty, 32'd4);
    check("tri_rising40", {31'd0, bus_a.rising}, 32'd0);
    go_to(48); check("tri_duty48", bus_a.duty, 32'd3);
    go_to(56); check("tri_duty56", bus_a.duty, 32'd2);
    go_to(64); check("tri_duty64", bus_a.duty, 32'd1);
    go_to(71); check("tri_rising71", {31'd0, bus_a.rising}, 32'd0);
    go_to(72); check("tri_duty72", bus_a.duty, 32'd0);
    check("tri_rising72", {31'd0, bus_a.rising}, 32'd1);
    go_to(80); check("tri_duty80", bus_a.duty, 32'd1);

    // Sawtooth.
    do_reset(1'b1);
    go_to(32); check("saw_duty32", bus_a.duty, 32'd4);
    check("saw_peak32", {31'd0, bus_a.at_peak}, 32'd1);
    go_to(39); check("saw_duty39", bus_a.duty, 32'd4);
    go_to(40); check("saw_duty40", bus_a.duty, 32'd0);
    check("saw_rising40", {31'd0, bus_a.rising}, 32'd1);
    check("saw_peak40", {31'd0, bus_a.at_peak}, 32'd0);
    go_to(48); check("saw_duty48", bus_a.duty, 32'd1);

    // Enable freeze over edges 21..30.
    do_reset(1'b0);
    go_to(20); check("en_duty20", bus_a.duty, 32'd2);
    check("en_ps20", {31'd0, bus_a.period_start}, 32'd1);
    @(negedge clk);
    bus_a.en = 1'b0;
    go_to(21); check("en_ps21", {31'd0, bus_a.period_start}, 32'd0);
    check("en_pcnt21", bus_a.period_cnt, 32'd0);
    go_to(30); check("en_pcnt30", bus_a.period_cnt, 32'd0);
    check("en_duty30", bus_a.duty, 32'd2);
    check("en_ps30", {31'd0, bus_a.period_start}, 32'd0);
    @(negedge clk);
    bus_a.en = 1'b1;
    go_to(31); check("en_pcnt31", bus_a.period_cnt, 32'd1);
    go_to(33); check("en_duty33", bus_a.duty, 32'd2);
    go_to(34); check("en_duty34", bus_a.duty, 32'd3);
    check("en_ps34", {31'd0, bus_a.period_start}, 32'd1);

    // Tick absorption: a step tick every clock still moves duty once per period.
    do_reset(1'b0);
    go_to(3);  check("abs_duty3", bus_b.duty, 32'd0);
    go_to(4);  check("abs_duty4", bus_b.duty, 32'd1);
    go_to(7);  check("abs_duty7", bus_b.duty, 32'd1);
    go_to(8);  check("abs_duty8", bus_b.duty, 32'd2);
    go_to(12); check("abs_duty12", bus_b.duty, 32'd3);

    // Asynchronous reset between clock edges.
    do_reset(1'b0);
    go_to(27); check("ar_duty27", bus_a.duty, 32'd3);
    check("ar_pcnt27", bus_a.period_cnt, 32'd3);
    #2;
    rst = 1'b0;
    #1;
    check("ar_duty_now",   bus_a.duty, 32'd0);
    check("ar_pcnt_now",   bus_a.period_cnt, 32'd0);
    check("ar_rising_now", {31'd0, bus_a.rising}, 32'd1);
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    go_to(7);  check("ar_duty7", bus_a.duty, 32'd0);
    go_to(8);  check("ar_duty8", bus_a.duty, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
